// File: rtl/uart_fifo_mm.sv
// Memory-mapped UART adapter: RX/TX FIFOs, sticky overflow flags and a
// status/control register on the port-B word bus.
module uart_fifo_mm #(
  parameter int unsigned BASE_ADDR  = 65537,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RX_DEPTH   = 16,
  parameter int unsigned TX_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] uart_din,
  input  logic                  uart_valid,
  input  logic                  uart_busy,
  output logic [DATA_WIDTH-1:0] uart_dout,
  output logic                  uart_wr,
  input  logic [31:0]           addr_b,
  input  logic [31:0]           data_b_in,
  input  logic [31:0]           data_b_we,
  output logic [31:0]           data_b,
  output logic                  strobe_b
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam logic [31:0]      BASE    = 32'(BASE_ADDR);
  localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
  localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);

  localparam logic [1:0] REG_RXVALID = 2'd0;
  localparam logic [1:0] REG_TXREADY = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [RX_AW-1:0]      rx_wr_ptr, rx_rd_ptr;
  logic [TX_AW-1:0]      tx_wr_ptr, tx_rd_ptr;
  logic [RX_CW-1:0]      rx_count;
  logic [TX_CW-1:0]      tx_count;
  logic                  rx_ovf, tx_ovf;

  logic [31:0] offset;
  logic [1:0]  reg_sel;
  logic        bus_we;
  logic        rd_data, wr_data, wr_ctrl;
  logic        flush, clr_rx_ovf, clr_tx_ovf;
  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        rx_pop_ok, rx_pop, rx_push, rx_ovf_set;
  logic        tx_can_drain, tx_pop, tx_push, tx_ovf_set;
  logic        unused_bits;

  // Window decode: offset wraps below BASE, so one compare covers both bounds.
  assign offset   = addr_b - BASE;
  assign strobe_b = (offset < 32'd4);
  assign reg_sel  = offset[1:0];
  assign bus_we   = data_b_we[0];

  assign rd_data  = strobe_b && !bus_we && (reg_sel == REG_DATA);
  assign wr_data  = strobe_b &&  bus_we && (reg_sel == REG_DATA);
  assign wr_ctrl  = strobe_b &&  bus_we && (reg_sel == REG_STATUS);

  assign clr_rx_ovf = wr_ctrl && data_b_in[0];
  assign clr_tx_ovf = wr_ctrl && data_b_in[1];
  assign flush      = wr_ctrl && data_b_in[2];

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL);
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL);

  // A same-cycle pop frees the slot a push into a full FIFO needs.
  assign rx_pop_ok  = rd_data && !rx_empty;
  assign rx_pop     = rx_pop_ok && !flush;
  assign rx_push    = uart_valid && (!rx_full || rx_pop_ok) && !flush;
  assign rx_ovf_set = uart_valid && rx_full && !rx_pop_ok;

  // Holding off while uart_wr is high limits the drain to one char per 2 cycles.
  assign tx_can_drain = !tx_empty && !uart_busy && !uart_wr;
  assign tx_pop       = tx_can_drain && !flush;
  assign tx_push      = wr_data && (!tx_full || tx_can_drain) && !flush;
  assign tx_ovf_set   = wr_data && tx_full && !tx_can_drain;

  assign unused_bits = ^{data_b_we[31:1], data_b_in};

  // Read mux
  always_comb begin
    data_b = '0;
    if (strobe_b) begin
      case (reg_sel)
        REG_RXVALID: data_b = 32'(!rx_empty);
        REG_TXREADY: data_b = 32'(!tx_full);
        REG_DATA:    data_b = rx_empty ? 32'd0 : 32'(rx_mem[rx_rd_ptr]);
        default:     data_b = {8'd0, 8'(tx_count), 8'(rx_count), 6'd0, tx_ovf, rx_ovf};
      endcase
    end
  end

  // FIFO storage; stale entries are harmless because pointers are reset.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= uart_din;
    if (tx_push) tx_mem[tx_wr_ptr] <= data_b_in[DATA_WIDTH-1:0];
  end

  // RX FIFO pointers and count
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
    end
  end

  // TX FIFO pointers and count
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
    end
  end

  // Sticky overflow flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (rx_ovf_set)      rx_ovf <= 1'b1;
      else if (clr_rx_ovf) rx_ovf <= 1'b0;
      if (tx_ovf_set)      tx_ovf <= 1'b1;
      else if (clr_tx_ovf) tx_ovf <= 1'b0;
    end
  end

  // Transmit strobe and character register
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_wr   <= 1'b0;
      uart_dout <= '0;
    end else if (tx_pop) begin
      uart_wr   <= 1'b1;
      uart_dout <= tx_mem[tx_rd_ptr];
    end else begin
      uart_wr   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_mm.sv
// Testbench for uart_fifo_mm: directed scenarios plus randomized bus/UART
// traffic checked against a queue-based reference model.
module tb_uart_fifo_mm;

  localparam int unsigned DW  = 8;
  localparam int unsigned RXD = 16;
  localparam int unsigned TXD = 16;
  localparam logic [31:0] BASE = 32'd65537;

  logic        clk, rst, uart_valid, uart_busy, uart_wr, strobe_b;
  logic [7:0]  uart_din, uart_dout;
  logic [31:0] addr_b, data_b_in, data_b_we, data_b;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       m_rx_ovf, m_tx_ovf, m_wr;
  logic [7:0] m_dout;
  int         n_vec, n_err;

  uart_fifo_mm #(.BASE_ADDR(65537), .DATA_WIDTH(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk(clk), .rst(rst), .uart_din(uart_din), .uart_valid(uart_valid),
    .uart_busy(uart_busy), .uart_dout(uart_dout), .uart_wr(uart_wr),
    .addr_b(addr_b), .data_b_in(data_b_in), .data_b_we(data_b_we),
    .data_b(data_b), .strobe_b(strobe_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what one clock edge does to the FIFO contents and flags.
  function automatic void model_edge();
    logic [31:0] off;
    logic win, we, flush, rd_pop, drain, rx_set, tx_set, wr_dat;
    if (rst) begin
      rx_q.delete(); tx_q.delete();
      m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_wr = 1'b0; m_dout = 8'd0;
      return;
    end
    off    = addr_b - BASE;
    win    = (off < 32'd4);
    we     = data_b_we[0];
    wr_dat = win && we && off == 32'd2;
    flush  = win && we && off == 32'd3 && data_b_in[2];
    rd_pop = win && !we && off == 32'd2 && rx_q.size() != 0;
    drain  = tx_q.size() != 0 && !uart_busy && !m_wr;
    rx_set = uart_valid && rx_q.size() == int'(RXD) && !rd_pop;
    tx_set = wr_dat && tx_q.size() == int'(TXD) && !drain;
    if (win && we && off == 32'd3) begin
      if (data_b_in[0]) m_rx_ovf = 1'b0;
      if (data_b_in[1]) m_tx_ovf = 1'b0;
    end
    if (rx_set) m_rx_ovf = 1'b1;
    if (tx_set) m_tx_ovf = 1'b1;
    if (flush) begin
      rx_q.delete(); tx_q.delete(); m_wr = 1'b0;
      return;
    end
    if (rd_pop) void'(rx_q.pop_front());
    if (uart_valid && !rx_set) rx_q.push_back(uart_din);
    if (drain) begin
      m_wr = 1'b1;
      m_dout = tx_q.pop_front();
    end else begin
      m_wr = 1'b0;
    end
    if (wr_dat && !tx_set) tx_q.push_back(data_b_in[7:0]);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    case (off)
      32'd0:   return 32'(rx_q.size() != 0);
      32'd1:   return 32'(tx_q.size() != int'(TXD));
      32'd2:   return (rx_q.size() != 0) ? 32'(rx_q[0]) : 32'd0;
      32'd3:   return {8'd0, 8'(tx_q.size()), 8'(rx_q.size()), 6'd0, m_tx_ovf, m_rx_ovf};
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Upper write-enable bits are randomized: only bit 0 may matter.
  task automatic set_bus(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr_b    = a;
    data_b_we = ($urandom() & 32'hFFFF_FFFE) | 32'(w);
    data_b_in = d;
  endtask

  task automatic bus_idle();
    set_bus(32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] exp [3];
    exp[0] = 32'd0; exp[1] = 32'd1; exp[2] = 32'd0;
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_vec++;
    if (uart_wr !== 1'b0 || uart_dout !== 8'd0) begin
      n_err++; $display("FAIL reset_uart: got wr=%b dout=%h expected wr=0 dout=00", uart_wr, uart_dout);
    end
    for (int i = 0; i < 3; i++) begin
      set_bus(BASE + 32'(i == 2 ? 3 : i), 1'b0, 32'd0); #1;
      n_vec++;
      if (data_b !== exp[i] || strobe_b !== 1'b1) begin
        n_err++; $display("FAIL reset_reg%0d: got %h strobe=%b expected %h strobe=1", i, data_b, strobe_b, exp[i]);
      end
    end
    set_bus(BASE - 32'd1, 1'b0, 32'd0); #1;
    n_vec++;
    if (strobe_b !== 1'b0 || data_b !== 32'd0) begin
      n_err++; $display("FAIL reset_outside: got %h strobe=%b expected 0 strobe=0", data_b, strobe_b);
    end
    bus_idle(); step();
  endtask

  task automatic test_tx_basic();
    uart_busy = 1'b0;
    set_bus(BASE + 32'd2, 1'b1, 32'h0000_0041); step();
    set_bus(BASE + 32'd2, 1'b1, 32'h0000_0042); step();
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      logic       ew;
      logic [7:0] ed;
      ew = (i % 2 == 0);
      ed = (i < 2) ? 8'h41 : 8'h42;
      n_vec++;
      if (uart_wr !== ew || (ew && uart_dout !== ed)) begin
        n_err++; $display("FAIL tx_basic_c%0d: got wr=%b dout=%h expected wr=%b dout=%h", i + 2, uart_wr, uart_dout, ew, ed);
      end
      step();
    end
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'd0) begin
      n_err++; $display("FAIL tx_basic_status: got %h expected 00000000", data_b);
    end
    bus_idle();
  endtask

  task automatic test_tx_overflow();
    int n;
    uart_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_bus(BASE + 32'd2, 1'b1, 32'(i)); step();
    end
    set_bus(BASE + 32'd1, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'd0) begin
      n_err++; $display("FAIL tx_full_txready: got %h expected 00000000", data_b);
    end
    set_bus(BASE + 32'd2, 1'b1, 32'h10); step();
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'h0010_0002) begin
      n_err++; $display("FAIL tx_ovf_status: got %h expected 00100002", data_b);
    end
    bus_idle();
    uart_busy = 1'b0;
    n = 0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (uart_wr) begin
        n_vec++;
        if (uart_dout !== 8'(n)) begin
          n_err++; $display("FAIL tx_drain_order: got %h expected %h", uart_dout, 8'(n));
        end
        n++;
      end
    end
    n_vec++;
    if (n != 16) begin
      n_err++; $display("FAIL tx_drain_count: got %0d expected 16", n);
    end
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'h0000_0002) begin
      n_err++; $display("FAIL tx_ovf_sticky: got %h expected 00000002", data_b);
    end
    set_bus(BASE + 32'd3, 1'b1, 32'd2); step();
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'd0) begin
      n_err++; $display("FAIL tx_ovf_clear: got %h expected 00000000", data_b);
    end
    bus_idle();
  endtask

  task automatic test_rx_overflow();
    bus_idle();
    for (int i = 0; i < 17; i++) begin
      uart_valid = 1'b1; uart_din = 8'(8'h60 + i); step();
    end
    uart_valid = 1'b0;
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'h0000_1001) begin
      n_err++; $display("FAIL rx_ovf_status: got %h expected 00001001", data_b);
    end
    for (int i = 0; i < 16; i++) begin
      set_bus(BASE + 32'd2, 1'b0, 32'd0); #1;
      n_vec++;
      if (data_b !== 32'(8'h60 + i)) begin
        n_err++; $display("FAIL rx_read_order: got %h expected %h", data_b, 32'(8'h60 + i));
      end
      step();
    end
    set_bus(BASE, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'd0) begin
      n_err++; $display("FAIL rx_empty_rxvalid: got %h expected 00000000", data_b);
    end
    set_bus(BASE + 32'd3, 1'b1, 32'd1); step();
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'd0) begin
      n_err++; $display("FAIL rx_ovf_clear: got %h expected 00000000", data_b);
    end
    bus_idle();
  endtask

  task automatic test_rx_full_pushpop();
    logic [7:0] vals [16];
    logic [7:0] d, e;
    bus_idle();
    for (int i = 0; i < 16; i++) begin
      vals[i] = 8'($urandom());
      uart_valid = 1'b1; uart_din = vals[i]; step();
    end
    uart_din = 8'h7E;
    set_bus(BASE + 32'd2, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'(vals[0])) begin
      n_err++; $display("FAIL full_pushpop_head: got %h expected %h", data_b, 32'(vals[0]));
    end
    step();
    uart_valid = 1'b0;
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'h0000_1000) begin
      n_err++; $display("FAIL full_pushpop_status: got %h expected 00001000", data_b);
    end
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? vals[i + 1] : 8'h7E;
      set_bus(BASE + 32'd2, 1'b0, 32'd0); #1;
      n_vec++;
      if (data_b !== 32'(e)) begin
        n_err++; $display("FAIL full_pushpop_drain%0d: got %h expected %h", i, data_b, 32'(e));
      end
      step();
    end
    d = 8'($urandom());
    uart_valid = 1'b1; uart_din = d;
    set_bus(BASE + 32'd2, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'd0) begin
      n_err++; $display("FAIL empty_pushread: got %h expected 00000000", data_b);
    end
    step();
    uart_valid = 1'b0;
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'h0000_0100) begin
      n_err++; $display("FAIL empty_pushread_status: got %h expected 00000100", data_b);
    end
    set_bus(BASE + 32'd2, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'(d)) begin
      n_err++; $display("FAIL empty_pushread_data: got %h expected %h", data_b, 32'(d));
    end
    step();
    bus_idle();
  endtask

  task automatic test_flush_reset();
    logic seen;
    uart_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      uart_valid = 1'b1; uart_din = 8'(8'hA0 + i);
      set_bus(BASE + 32'd2, 1'b1, 32'(8'hB0 + i)); step();
    end
    uart_valid = 1'b0;
    uart_busy = 1'b0;
    set_bus(BASE + 32'd3, 1'b1, 32'd4); step();
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'd0) begin
      n_err++; $display("FAIL flush_status: got %h expected 00000000", data_b);
    end
    bus_idle();
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (uart_wr) seen = 1'b1;
      step();
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL flush_no_strobe: got strobe=%b expected strobe=0", seen);
    end
    set_bus(BASE + 32'd2, 1'b1, 32'h5A); step();
    set_bus(BASE + 32'd2, 1'b1, 32'h5B); step();
    bus_idle();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (uart_wr) seen = 1'b1;
      else step();
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL rst_drain_timeout: got no strobe expected strobe within 10 cycles");
    end
    rst = 1'b1; step(); rst = 1'b0;
    n_vec++;
    if (uart_wr !== 1'b0 || uart_dout !== 8'd0) begin
      n_err++; $display("FAIL rst_mid_drain: got wr=%b dout=%h expected wr=0 dout=00", uart_wr, uart_dout);
    end
    set_bus(BASE + 32'd3, 1'b0, 32'd0); #1;
    n_vec++;
    if (data_b !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_drain_status: got %h expected 00000000", data_b);
    end
    bus_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      int unsigned sel;
      logic        w, es;
      logic [31:0] a, d, ed;
      logic        busy_phase;
      busy_phase = ((c / 250) % 2) == 0;
      rst        = ($urandom_range(0, 399) == 0);
      uart_busy  = busy_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      uart_valid = busy_phase ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0);
      uart_din   = 8'($urandom());
      sel = $urandom_range(0, 8);
      case (sel)
        0:       a = BASE - 32'd1;
        5:       a = BASE + 32'd4;
        6, 7:    a = BASE + 32'd2;
        8:       a = 32'($urandom());
        default: a = BASE + 32'(sel - 1);
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom();
      if (a == BASE + 32'd3 && $urandom_range(0, 7) != 0) d[2] = 1'b0;
      set_bus(a, w, d);
      #1;
      es = (a - BASE) < 32'd4;
      n_vec++;
      if (strobe_b !== es) begin
        n_err++; $display("FAIL rand_strobe: got %b expected %b addr=%h", strobe_b, es, a);
      end
      if (!w) begin
        ed = exp_read(a);
        n_vec++;
        if (data_b !== ed) begin
          n_err++; $display("FAIL rand_read: got %h expected %h addr=%h cycle=%0d", data_b, ed, a, c);
        end
      end
      step();
      n_vec++;
      if (uart_wr !== m_wr || uart_dout !== m_dout) begin
        n_err++; $display("FAIL rand_tx: got wr=%b dout=%h expected wr=%b dout=%h cycle=%0d", uart_wr, uart_dout, m_wr, m_dout, c);
      end
    end
    rst = 1'b1; bus_idle(); uart_valid = 1'b0; step(); rst = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; uart_valid = 1'b0; uart_busy = 1'b0; uart_din = 8'd0;
    addr_b = 32'd0; data_b_in = 32'd0; data_b_we = 32'd0;
    m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_wr = 1'b0; m_dout = 8'd0;
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_overflow();
    test_rx_full_pushpop();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_fifo_mm.md
Name: uart_fifo_mm

Overview:
Memory-mapped UART adapter for the SoC data port (port B). It replaces the single-register UART window with parametrised RX and TX FIFOs, sticky overflow flags, and a status/control register. The block sits on the same addr_b/data_b bus as socram and ledwriter. It drives the external UART byte interface (uart_din/uart_valid in, uart_dout/uart_wr out).

Parameters:
BASE_ADDR, 65537, word address of register 0; the window is BASE_ADDR..BASE_ADDR+3.
DATA_WIDTH, 8, UART character width (1..16).
RX_DEPTH, 16, RX FIFO entries; power of two, 2..128.
TX_DEPTH, 16, TX FIFO entries; power of two, 2..128.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
uart_din  in  DATA_WIDTH  received character
uart_valid  in  1  one-cycle strobe; uart_din is valid this cycle
uart_busy  in  1  transmitter cannot accept a character
uart_dout  out  DATA_WIDTH  character to transmit (registered)
uart_wr  out  1  one-cycle transmit strobe (registered)
addr_b  in  32  bus word address
data_b_in  in  32  bus write data
data_b_we  in  32  bus write enable; bit 0 is significant
data_b  out  32  bus read data (combinational)
strobe_b  out  1  address hits this block's window (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset, both FIFOs are emptied (pointers and counts = 0), rx_ovf = tx_ovf = 0, uart_wr = 0 and uart_dout = 0. Reset has priority over every other event in that cycle, including an in-flight push, pop or transmit; that data is lost.
- Bus access: one access equals one cycle. A write is addr in window with data_b_we[0] = 1. A read is addr in window with data_b_we[0] = 0.
- strobe_b = (BASE_ADDR <= addr_b <= BASE_ADDR+3).
- Register map (read data is zero-extended; data_b = 0 outside the window):
  - +0 RXVALID: read returns rx_count != 0.
  - +1 TXREADY: read returns tx_count != TX_DEPTH.
  - +2 DATA:
    - Read returns the RX head combinationally and pops it at the clock edge when RX is non-empty.
    - A read of DATA while RX is empty returns 0 and pops nothing.
    - A write pushes data_b_in[DATA_WIDTH-1:0] into TX.
  - +3 STATUS/CTRL:
    - Read returns {8'b0, tx_count[7:0], rx_count[7:0], 6'b0, tx_ovf, rx_ovf}.
    - Write: bit0 = 1 clears rx_ovf, bit1 = 1 clears tx_ovf, bit2 = 1 flushes both FIFOs.
    - A flush discards any push or pop in the same cycle. An active uart_wr strobe still completes.
- RX push:
  - Each cycle with uart_valid = 1 pushes uart_din.
  - If RX is full and there is no same-cycle pop, the character is dropped and rx_ovf is set (sticky).
  - Full plus push plus pop in one cycle: both happen, rx_count is unchanged, no overflow.
  - Empty plus push plus DATA read in one cycle: the read returns 0, the push is kept, rx_count becomes 1.
  - rx_ovf set and clear in the same cycle: set wins.
- TX push:
  - A write to DATA when TX is full and there is no same-cycle drain drops the character and sets tx_ovf (sticky).
  - A write to DATA on the same edge that drains a full FIFO is accepted.
- TX drain:
  - At an edge where tx_count != 0 and uart_busy = 0 and uart_wr = 0, the block sets uart_wr <= 1 and uart_dout <= TX head, and pops TX.
  - Otherwise uart_wr <= 0; uart_dout holds its value.
  - Throughput is at most one character per 2 cycles.
  - Latency: a DATA write in cycle N gives uart_wr = 1 in cycle N+2 when the transmitter is idle and not busy.
- Pointers and counts: pointers wrap modulo depth. Counts are $clog2(DEPTH)+1 bits wide.
- Flag ordering: FIFO state is updated at the edge. RXVALID/TXREADY reflect post-edge state in the next cycle.

Test Plan:
1. Reset, then read +0, +1, +3 -> 0, 1, 0x00000000; uart_wr = 0.
2. Write 0x41 and then 0x42 to DATA with uart_busy = 0 -> uart_wr pulses in cycles N+2 and N+4 with uart_dout 0x41, then 0x42; tx_count returns to 0.
3. Hold uart_busy = 1 and write 17 bytes 0x00..0x10 (TX_DEPTH = 16) -> TXREADY = 0 after 16 writes; the 17th is dropped; STATUS = 0x00100002. Release busy -> 16 strobes, 0x00..0x0F in order.
4. Push 17 RX chars 0x60..0x70 -> STATUS = 0x00001001. Read DATA 16 times -> 0x60..0x6F. Write 1 to +3 -> rx_ovf = 0.
5. RX full, then uart_valid (0x7E) and a DATA read in the same cycle -> read returns the old head, 0x7E is accepted, rx_ovf stays 0, count stays 16.
6. Write 4 to +3 while both FIFOs are non-empty -> both counts are 0 next cycle and no further uart_wr. Assert rst mid-drain -> uart_wr = 0 and uart_dout = 0 next cycle.
